moore_mode_counter: RTL

MOORE_MODE_COUNTER -- requirements
Module: moore_mode_counter

---
 rtl/moore_mode_counter_if.sv | 28 ++
 rtl/moore_mode_counter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/moore_mode_counter_if.sv
// Bus bundle for moore_mode_counter.
// Signalling: there is no valid/ready pair on this bus. en and load are
// single-cycle strobes that the counter samples on every rising clk edge,
// and load wins over en. count/tc/dir/gray are registered Moore outputs
// that may be read at any time.
// Optional feature macro: MOORE_CNT_GRAY_EN (see moore_mode_counter.sv).
interface moore_mode_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             dir;
  logic [WIDTH-1:0] gray;

  modport master (
    output en, mode, load, load_val,
    input  count, tc, dir, gray
  );

  modport slave (
    input  en, mode, load, load_val,
    output count, tc, dir, gray
  );
endinterface

// File: rtl/moore_mode_counter.sv
// Moore-style multi-mode counter: up-wrap, down-wrap, bounce, one-shot up.
// All outputs derive from the registered state and count only.
// Optional feature macro MOORE_CNT_GRAY_EN: when defined, a registered
// Gray-code image of count is produced on bus.gray; otherwise gray is 0.
// dbg_state exposes the FSM state encoding for checkers.
module moore_mode_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic                 clk,
  input  logic                 reset,
  moore_mode_counter_if.slave  bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  localparam logic [1:0] M_UP      = 2'b00;
  localparam logic [1:0] M_DOWN    = 2'b01;
  localparam logic [1:0] M_BOUNCE  = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

  // State and count registers; reset returns to IDLE with count 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and next-count: load beats en, en beats hold.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      state_d = (bus.mode == M_DOWN) ? DOWN : UP;
    end else if (bus.en) begin
      case (state_q)
        IDLE: begin
          // Start latency: pick a direction, leave count untouched.
          state_d = (bus.mode == M_DOWN) ? DOWN : UP;
        end
        UP: begin
          if (bus.mode == M_DOWN) begin
            state_d = DOWN;
            count_d = (count_q == ZERO_V) ? MAX_V : count_q - ONE_V;
          end else if (count_q != MAX_V) begin
            count_d = count_q + ONE_V;
          end else begin
            case (bus.mode)
              M_UP:     count_d = ZERO_V;
              M_BOUNCE: begin
                count_d = MAX_V - ONE_V;
                state_d = DOWN;
              end
              default:  state_d = DONE;
            endcase
          end
        end
        DOWN: begin
          if (bus.mode == M_UP || bus.mode == M_ONESHOT) begin
            // Reversal to counting up happens on this same edge.
            if (count_q != MAX_V) begin
              count_d = count_q + ONE_V;
              state_d = UP;
            end else if (bus.mode == M_UP) begin
              count_d = ZERO_V;
              state_d = UP;
            end else begin
              state_d = DONE;
            end
          end else if (count_q != ZERO_V) begin
            count_d = count_q - ONE_V;
          end else if (bus.mode == M_DOWN) begin
            count_d = MAX_V;
          end else begin
            count_d = ONE_V;
            state_d = UP;
          end
        end
        default: begin
          // DONE is sticky until load or reset.
        end
      endcase
    end
  end

`ifdef MOORE_CNT_GRAY_EN
  logic [WIDTH-1:0] gray_q;

  // Gray image registered from the next count so it tracks count exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_d ^ (count_d >> 1);
    end
  end

  assign bus.gray = gray_q;
`else
  assign bus.gray = '0;
`endif

  assign bus.count = count_q;
  assign bus.tc    = (state_q == UP   && count_q == MAX_V)  ||
                     (state_q == DOWN && count_q == ZERO_V) ||
                     (state_q == DONE);
  assign bus.dir   = (state_q == DOWN);
  assign dbg_state = state_q;

endmodule
